// File: rtl/ssc_pkg.sv
// ----------------------------------------------------------------------------
// ssc_pkg
// Constants and types shared by the SSC serial transmitter and the SSC
// serial-sequence receiver: nibble width, the sync header nibble and the
// frame state encoding.
// ----------------------------------------------------------------------------
package ssc_pkg;

    localparam int SSC_NIBBLE_W = 4;

    localparam logic [SSC_NIBBLE_W-1:0] SSC_SYNC_WORD = 4'b1101;

    typedef enum logic [1:0] {
        SSC_IDLE = 2'd0,
        SSC_SYNC = 2'd1,
        SSC_DATA = 2'd2,
        SSC_GAP  = 2'd3
    } ssc_state_e;

endpackage

// File: rtl/ssc_hold_reg.sv
// ----------------------------------------------------------------------------
// ssc_hold_reg
// One-entry holding register between the nibble source and the transmitter
// shifter. A nibble is accepted whenever the register is empty; the consumer
// empties it with take_i.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (register empty)
//   data_i   incoming nibble
//   valid_i  incoming nibble valid
//   ready_o  register empty, a nibble may be accepted this cycle
//   take_i   consumer removes the held nibble on this edge
//   full_o   register holds a nibble
//   data_o   held nibble
// ----------------------------------------------------------------------------
module ssc_hold_reg
    import ssc_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [SSC_NIBBLE_W-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    take_i,
    output logic                    full_o,
    output logic [SSC_NIBBLE_W-1:0] data_o
);

    logic                    full_q;
    logic                    full_d;
    logic [SSC_NIBBLE_W-1:0] data_q;
    logic [SSC_NIBBLE_W-1:0] data_d;
    logic                    accept;

    assign accept = valid_i && !full_q;

    // A take and a new accept on the same edge leave the register full:
    // the accept is applied last so it wins.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (take_i) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ssc_serial_tx.sv
// ----------------------------------------------------------------------------
// ssc_serial_tx
// Serial frame transmitter for the SSC receiver data_in line. Each frame is
// the sync nibble followed by FRAME_NIBBLES payload nibbles, shifted out
// MSB-first at one bit per clk_main cycle. Missing payload aborts the frame
// with an underrun pulse; an optional idle gap separates frames.
//
// Ports:
//   clk_main    system clock, rising edge
//   rst         synchronous active-high reset
//   in_data     payload nibble
//   in_valid    in_data valid
//   in_ready    holding register empty (combinational from the register)
//   serial_out  registered serial bit stream
//   busy        frame in progress (sync, payload or gap)
//   frame_done  one-cycle pulse after the last payload bit cycle
//   underrun    one-cycle pulse when a frame aborts for lack of data
// ----------------------------------------------------------------------------
module ssc_serial_tx
    import ssc_pkg::*;
#(
    parameter logic [SSC_NIBBLE_W-1:0] SYNC_WORD     = SSC_SYNC_WORD,
    parameter int unsigned             FRAME_NIBBLES = 2,
    parameter logic                    IDLE_LEVEL    = 1'b0,
    parameter int unsigned             GAP_CYCLES    = 0
) (
    input  logic                    clk_main,
    input  logic                    rst,
    input  logic [SSC_NIBBLE_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    serial_out,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun
);

    localparam logic [3:0] LAST_NIB = 4'(FRAME_NIBBLES);
    localparam logic [3:0] GAP_LEN  = 4'(GAP_CYCLES);

    ssc_state_e              state_q;
    logic [SSC_NIBBLE_W-1:0] shift_q;
    logic [1:0]              bit_cnt_q;
    logic [3:0]              nib_cnt_q;
    logic [3:0]              gap_cnt_q;
    logic                    serial_q;
    logic                    busy_q;
    logic                    frame_done_q;
    logic                    underrun_q;

    logic                    hold_full;
    logic [SSC_NIBBLE_W-1:0] hold_data;
    logic                    hold_take;

    logic                    nib_boundary;
    logic                    more_payload;
    logic                    frame_end;
    logic                    starve;
    logic                    launch;

    ssc_hold_reg u_hold (
        .clk_i   (clk_main),
        .rst_i   (rst),
        .data_i  (in_data),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .take_i  (hold_take),
        .full_o  (hold_full),
        .data_o  (hold_data)
    );

    // bit_cnt wraps to 0 once the fourth bit of the current nibble (sync or
    // payload) is on the wire; that edge decides what comes next.
    assign nib_boundary = ((state_q == SSC_SYNC) || (state_q == SSC_DATA))
                          && (bit_cnt_q == 2'd0);
    assign more_payload = (state_q == SSC_SYNC) || (nib_cnt_q < LAST_NIB);
    assign frame_end    = nib_boundary && !more_payload;
    assign starve       = nib_boundary && more_payload && !hold_full;
    assign hold_take    = nib_boundary && more_payload && hold_full;

    // A new frame starts from IDLE, straight after the last payload bit when
    // there is no gap, or on the edge that ends the gap, so queued frames
    // follow each other with no extra idle cycle.
    assign launch = hold_full &&
                    ((state_q == SSC_IDLE) ||
                     (frame_end && (GAP_LEN == 4'd0)) ||
                     ((state_q == SSC_GAP) && (gap_cnt_q >= GAP_LEN)));

    always_ff @(posedge clk_main) begin
        if (rst) begin
            state_q      <= SSC_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            nib_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            serial_q     <= IDLE_LEVEL;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            underrun_q   <= starve;
            if (launch) begin
                // First sync bit goes straight out; the rest wait in the shifter.
                state_q   <= SSC_SYNC;
                serial_q  <= SYNC_WORD[3];
                shift_q   <= {SYNC_WORD[2:0], 1'b0};
                bit_cnt_q <= 2'd1;
                nib_cnt_q <= '0;
                gap_cnt_q <= '0;
                busy_q    <= 1'b1;
            end else if (starve) begin
                state_q   <= SSC_IDLE;
                serial_q  <= IDLE_LEVEL;
                shift_q   <= '0;
                bit_cnt_q <= '0;
                nib_cnt_q <= '0;
                gap_cnt_q <= '0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    SSC_SYNC, SSC_DATA: begin
                        if (bit_cnt_q != 2'd0) begin
                            serial_q  <= shift_q[3];
                            shift_q   <= {shift_q[2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 2'd1;
                        end else if (hold_take) begin
                            // Seamless load: the held nibble's MSB follows
                            // the previous nibble's LSB with no bubble.
                            state_q   <= SSC_DATA;
                            serial_q  <= hold_data[3];
                            shift_q   <= {hold_data[2:0], 1'b0};
                            bit_cnt_q <= 2'd1;
                            nib_cnt_q <= nib_cnt_q + 4'd1;
                        end else begin
                            serial_q  <= IDLE_LEVEL;
                            shift_q   <= '0;
                            nib_cnt_q <= '0;
                            if (GAP_LEN != 4'd0) begin
                                state_q   <= SSC_GAP;
                                gap_cnt_q <= 4'd1;
                                busy_q    <= 1'b1;
                            end else begin
                                state_q <= SSC_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    SSC_GAP: begin
                        serial_q <= IDLE_LEVEL;
                        if (gap_cnt_q < GAP_LEN) begin
                            gap_cnt_q <= gap_cnt_q + 4'd1;
                        end else begin
                            state_q   <= SSC_IDLE;
                            gap_cnt_q <= '0;
                            busy_q    <= 1'b0;
                        end
                    end
                    default: begin
                        serial_q <= IDLE_LEVEL;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_ssc_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_ssc_serial_tx
// Two transmitters share clock and reset: lane 0 with no inter-frame gap and
// lane 1 with a three-cycle gap. Each lane has a behavioural model that
// describes the wire as a queue of pending bits; every edge the model pushes
// the expected output set into a scoreboard that a negedge monitor drains.
// ----------------------------------------------------------------------------
module tb_ssc_serial_tx;

    localparam int         NIBBLES  = 2;
    localparam logic [3:0] SYNC     = 4'b1101;
    localparam logic       IDLE_LVL = 1'b0;
    localparam int         M_IDLE   = 0;
    localparam int         M_FRAME  = 1;
    localparam int         M_GAP    = 2;

    logic       clock;
    logic       reset;
    logic [1:0] inValid;
    logic [3:0] inData [2];
    logic [1:0] inReady;
    logic [1:0] serialO;
    logic [1:0] busyO;
    logic [1:0] doneO;
    logic [1:0] underO;

    int testsRun    = 0;
    int testsFailed = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int GAP = (g == 0) ? 0 : 3;

        ssc_serial_tx #(
            .SYNC_WORD     (SYNC),
            .FRAME_NIBBLES (NIBBLES),
            .IDLE_LEVEL    (IDLE_LVL),
            .GAP_CYCLES    (GAP)
        ) dut (
            .clk_main   (clock),
            .rst        (reset),
            .in_data    (inData[g]),
            .in_valid   (inValid[g]),
            .in_ready   (inReady[g]),
            .serial_out (serialO[g]),
            .busy       (busyO[g]),
            .frame_done (doneO[g]),
            .underrun   (underO[g])
        );

        bit         holdFull = 1'b0;
        logic [3:0] holdData = '0;
        bit         wireQ [$];
        int         mode    = M_IDLE;
        int         nibLeft = 0;
        int         gapLeft = 0;
        logic [4:0] expQ [$];

        // Reference: a frame is the sync bits then each payload nibble's
        // bits, fetched from the holding slot when the wire queue runs dry.
        always @(posedge clock) begin : model
            bit   accept;
            bit   takeHold;
            bit   tryStart;
            bit   done;
            bit   under;
            logic wireBit;
            if (reset) begin
                holdFull = 1'b0;
                holdData = '0;
                wireQ.delete();
                mode     = M_IDLE;
                nibLeft  = 0;
                gapLeft  = 0;
                expQ.push_back({IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b1});
            end else begin
                accept   = inValid[g] && !holdFull;
                takeHold = 1'b0;
                tryStart = 1'b0;
                done     = 1'b0;
                under    = 1'b0;
                wireBit  = IDLE_LVL;
                if (mode == M_IDLE) begin
                    tryStart = 1'b1;
                end else if (mode == M_GAP) begin
                    if (gapLeft > 0) gapLeft--;
                    else tryStart = 1'b1;
                end else begin
                    if (wireQ.size() > 0) begin
                        wireBit = wireQ.pop_front();
                    end else if (nibLeft > 0) begin
                        if (holdFull) begin
                            takeHold = 1'b1;
                            nibLeft--;
                            for (int i = 3; i >= 0; i--) wireQ.push_back(holdData[i]);
                            wireBit = wireQ.pop_front();
                        end else begin
                            under = 1'b1;
                            mode  = M_IDLE;
                        end
                    end else begin
                        done = 1'b1;
                        if (GAP > 0) begin
                            mode    = M_GAP;
                            gapLeft = GAP - 1;
                        end else begin
                            tryStart = 1'b1;
                        end
                    end
                end
                if (tryStart) begin
                    if (holdFull) begin
                        mode    = M_FRAME;
                        nibLeft = NIBBLES;
                        for (int i = 3; i >= 0; i--) wireQ.push_back(SYNC[i]);
                        wireBit = wireQ.pop_front();
                    end else begin
                        mode = M_IDLE;
                    end
                end
                if (takeHold) holdFull = 1'b0;
                if (accept) begin
                    holdFull = 1'b1;
                    holdData = inData[g];
                end
                expQ.push_back({wireBit, (mode != M_IDLE), done, under, !holdFull});
            end
        end

        always @(negedge clock) begin : monitor
            logic [4:0] e;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput($sformatf("lane%0d serial_out", g), 32'(serialO[g]), 32'(e[4]));
                checkOutput($sformatf("lane%0d busy", g),       32'(busyO[g]),   32'(e[3]));
                checkOutput($sformatf("lane%0d frame_done", g), 32'(doneO[g]),   32'(e[2]));
                checkOutput($sformatf("lane%0d underrun", g),   32'(underO[g]),  32'(e[1]));
                checkOutput($sformatf("lane%0d in_ready", g),   32'(inReady[g]), 32'(e[0]));
            end
        end
    end

    // Holds in_valid until the lane accepts; returns at the negedge after
    // the accepting edge with in_valid still high.
    task automatic sendNibble(input int k, input logic [3:0] d);
        int   guard;
        logic rdy;
        guard      = 0;
        inValid[k] = 1'b1;
        inData[k]  = d;
        do begin
            rdy = inReady[k];
            @(negedge clock);
            guard++;
        end while (!rdy && guard < 100);
        checkOutput($sformatf("lane%0d handshake", k), 32'(rdy), 32'd1);
    endtask

    task automatic captureFrame(input int k, output logic [31:0] bits, output int n);
        int waitCnt;
        waitCnt = 0;
        bits    = '0;
        n       = 0;
        while (!busyO[k] && waitCnt < 50) begin
            @(negedge clock);
            waitCnt++;
        end
        while (busyO[k] && n < 32) begin
            bits = {bits[30:0], serialO[k]};
            n++;
            @(negedge clock);
        end
    endtask

    task automatic applyStimulus(input int cycles, input int pct);
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < 2; k++) begin
                inValid[k] = ($urandom_range(0, 99) < pct);
                inData[k]  = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clock);
        end
        reset   = 1'b0;
        inValid = '0;
    endtask

    initial begin
        logic [31:0] bits;
        int          n;
        reset     = 1'b1;
        inValid   = '0;
        inData[0] = '0;
        inData[1] = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        repeat (10) @(negedge clock);
        checkOutput("idle serial_out", 32'(serialO[0]), 32'd0);
        checkOutput("idle in_ready",   32'(inReady[0]), 32'd1);
        checkOutput("idle busy",       32'(busyO[0]),   32'd0);

        fork
            captureFrame(0, bits, n);
            begin
                sendNibble(0, 4'b1000);
                sendNibble(0, 4'b0111);
                inValid[0] = 1'b0;
            end
        join
        checkOutput("frame 8/7 length", 32'(n), 32'd12);
        checkOutput("frame 8/7 bits", 32'(bits[11:0]), 32'h0D87);
        repeat (5) @(negedge clock);

        fork
            captureFrame(0, bits, n);
            begin
                sendNibble(0, 4'b1010);
                inValid[0] = 1'b0;
            end
        join
        checkOutput("underrun length", 32'(n), 32'd8);
        checkOutput("underrun bits", 32'(bits[7:0]), 32'h00DA);
        repeat (5) @(negedge clock);

        fork
            captureFrame(0, bits, n);
            begin
                sendNibble(0, 4'h3);
                sendNibble(0, 4'hC);
                sendNibble(0, 4'h5);
                sendNibble(0, 4'hA);
                inValid[0] = 1'b0;
            end
        join
        checkOutput("back-to-back length", 32'(n), 32'd24);
        checkOutput("back-to-back bits", 32'(bits[23:0]), 32'h00D3CD5A);
        repeat (5) @(negedge clock);

        sendNibble(0, 4'h9);
        sendNibble(0, 4'h6);
        inValid[0] = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid-frame reset serial_out", 32'(serialO[0]), 32'd0);
        checkOutput("mid-frame reset in_ready",   32'(inReady[0]), 32'd1);
        checkOutput("mid-frame reset busy",       32'(busyO[0]),   32'd0);
        fork
            captureFrame(0, bits, n);
            begin
                sendNibble(0, 4'h5);
                sendNibble(0, 4'h6);
                inValid[0] = 1'b0;
            end
        join
        checkOutput("post-reset frame length", 32'(n), 32'd12);
        checkOutput("post-reset frame bits", 32'(bits[11:0]), 32'h0D56);
        repeat (5) @(negedge clock);

        fork
            captureFrame(1, bits, n);
            begin
                sendNibble(1, 4'h3);
                sendNibble(1, 4'hC);
                sendNibble(1, 4'h5);
                sendNibble(1, 4'hA);
                inValid[1] = 1'b0;
            end
        join
        checkOutput("gap frames length", 32'(n), 32'd30);
        checkOutput("gap frames bits", 32'(bits[29:0]),
                    32'({12'hD3C, 3'b000, 12'hD5A, 3'b000}));
        repeat (5) @(negedge clock);

        applyStimulus(1000, 90);
        applyStimulus(1000, 35);
        applyStimulus(1000, 70);

        repeat (40) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
